fifo_rd_rr_sched: RTL

Round-robin read scheduler that shares one output stream among NUM_CH async-FIFO read sides, all in the read-clock domain. Each channel exposes the standard FIFO read interface: registered rempty, pop strobe rinc, and combinational rdata valid whenever rempty=0. The block grants one channel at a time for a burst of up to BURST_MAX words, pops words, and registers them onto a valid/ready stream tagged with the source channel id.

---
 rtl/fifo_rd_rr_sched.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/fifo_rd_rr_sched.sv
// Round-robin read scheduler: shares one registered valid/ready stream among NUM_CH FIFO read sides.
// Optional per-grant last-beat flag on m_tlast is built when SCHED_TLAST_EN is defined.
module fifo_rd_rr_sched #(
    parameter int NUM_CH    = 4,
    parameter int DWIDTH    = 32,
    parameter int BURST_MAX = 8,
    parameter int IDW       = 2
) (
    input  logic                     rclk,
    input  logic                     rrst_n,
    input  logic                     enable,
    input  logic [NUM_CH-1:0]        rempty,
    input  logic [NUM_CH*DWIDTH-1:0] rdata,
    output logic [NUM_CH-1:0]        rinc,
    output logic [DWIDTH-1:0]        m_tdata,
    output logic                     m_tvalid,
    input  logic                     m_tready,
    output logic [IDW-1:0]           m_tid,
    output logic                     m_tlast,
    output logic                     busy
);

    localparam int            CW        = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_MAX - 1);

    typedef enum logic {ARB, BURST} state_e;

    state_e            state_q, state_d;
    logic [IDW-1:0]    grant_q, grant_d;
    logic [IDW-1:0]    last_grant_q, last_grant_d;
    logic [CW-1:0]     beat_cnt_q, beat_cnt_d;

    logic              out_free;
    logic              pop;
    logic              last_beat;
    logic              sel_empty;
    logic [DWIDTH-1:0] sel_data;
    logic              arb_hit;
    logic [IDW-1:0]    arb_ch;

    assign out_free  = !m_tvalid || m_tready;
    assign last_beat = (beat_cnt_q == LAST_BEAT);

    // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
    always_comb begin
        sel_data  = '0;
        sel_empty = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant_q == IDW'(i)) begin
                sel_data  = rdata[i*DWIDTH +: DWIDTH];
                sel_empty = rempty[i];
            end
        end
    end

    // Rank 0 is the channel right after last_grant; the lowest-ranked non-empty channel wins.
    always_comb begin
        int rank;
        int best;
        best   = NUM_CH;
        rank   = 0;
        arb_ch = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            rank = (i + 2*NUM_CH - 1 - int'(last_grant_q)) % NUM_CH;
            if (!rempty[i] && rank < best) begin
                best   = rank;
                arb_ch = IDW'(i);
            end
        end
        arb_hit = (best < NUM_CH);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            state_q      <= ARB;
            grant_q      <= '0;
            last_grant_q <= IDW'(NUM_CH - 1);
            beat_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        case (state_q)
            ARB: begin
                if (enable && arb_hit) begin
                    state_d    = BURST;
                    grant_d    = arb_ch;
                    beat_cnt_d = '0;
                end
            end
            BURST: begin
                if (sel_empty || !enable) begin
                    state_d      = ARB;
                    last_grant_d = grant_q;
                end else if (pop) begin
                    beat_cnt_d = beat_cnt_q + CW'(1);
                    if (last_beat) begin
                        state_d      = ARB;
                        last_grant_d = grant_q;
                    end
                end
            end
            default: state_d = ARB;
        endcase
    end

    // Pop is gated by rrst_n so a reset cycle never drains a word that would then be discarded.
    always_comb begin
        busy = (state_q == BURST);
        pop  = busy && !sel_empty && out_free && enable && rrst_n;
        rinc = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            rinc[i] = pop && (grant_q == IDW'(i));
        end
    end

    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
            m_tid    <= '0;
        end else if (pop) begin
            m_tvalid <= 1'b1;
            m_tdata  <= sel_data;
            m_tid    <= grant_q;
        end else if (m_tready) begin
            m_tvalid <= 1'b0;
        end
    end

`ifdef SCHED_TLAST_EN
    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            m_tlast <= 1'b0;
        end else if (pop) begin
            m_tlast <= last_beat;
        end
    end
`else
    assign m_tlast = 1'b0;
`endif

endmodule
